// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port memory arbiter and sequencer with ROM write protection
//
// Serializes transactions from two masters (port 0: MIPS core, port 1: loader/debug)
// onto one memory port. Reads wait RD_LATENCY cycles for mem_rdata_i; writes below
// RAM_BASE are suppressed at the memory and reported with errN_o alongside ackN_o.
//
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration on
// simultaneous requests; otherwise port 0 has fixed priority.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   req*_i, we*_i, addr*_i, wdata*_i per-master request, direction, address, data
//   ack*_o, err*_o                   per-master completion pulse, ROM-write error
//   rdata_o                          registered read data shared by both masters
//   mem_addr_o, mem_wdata_o          address/data to memory, held between transactions
//   mem_we_o                         memory write enable, ISSUE cycle of RAM writes only
//   mem_rdata_i                      memory read data
module mem_arbiter #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RAM_BASE   = DATA_WIDTH'(32'h1000_0000),
  parameter int                    RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_i,
  input  logic                  req1_i,
  input  logic                  we0_i,
  input  logic                  we1_i,
  input  logic [DATA_WIDTH-1:0] addr0_i,
  input  logic [DATA_WIDTH-1:0] addr1_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  output logic                  ack0_o,
  output logic                  ack1_o,
  output logic                  err0_o,
  output logic                  err1_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_we_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  // WAIT lasts RD_LATENCY cycles; the counter runs 0..RD_LATENCY-1.
  localparam logic [1:0] CNT_LAST = 2'(RD_LATENCY - 1);

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  grant1;
  logic                  rom_hit;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic                  last_q, last_d;
`endif

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign rdata_o     = rdata_q;
  assign rom_hit     = (addr_q < RAM_BASE);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    ack0_o   = 1'b0;
    ack1_o   = 1'b0;
    err0_o   = 1'b0;
    err1_o   = 1'b0;
    mem_we_o = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d   = last_q;
    // On contention the port that was not granted last wins.
    grant1   = req1_i & (~req0_i | ~last_q);
`else
    grant1   = req1_i & ~req0_i;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (req0_i || req1_i) begin
          owner_d = grant1;
          we_d    = grant1 ? we1_i    : we0_i;
          addr_d  = grant1 ? addr1_i  : addr0_i;
          wdata_d = grant1 ? wdata1_i : wdata0_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_we_o = we_q & ~rom_hit;
        cnt_d    = 2'd0;
        state_d  = we_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          rdata_d = mem_rdata_i;
          cnt_d   = 2'd0;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 2'd1;
        end
      end
      S_DONE: begin
        ack0_o  = ~owner_q;
        ack1_o  = owner_q;
        err0_o  = ~owner_q & we_q & rom_hit;
        err1_o  = owner_q & we_q & rom_hit;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d  = owner_q;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= 2'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule
